// File: rtl/p25519_pkg.sv
// Shared constants and types for arithmetic modulo p = 2^255 - 19.
//   P25519            : the field prime, 256 bits wide (bit 255 is 0)
//   FOLD_HI / FOLD_TOP: 2^256 = 38 and 2^255 = 19 (mod p)
//   LIMB_W / N_LIMBS  : limb-serial datapath geometry (16 x 16 bits)
//   CARRY_W           : limb carry width; a carry never exceeds 39
//   state_t           : reducer FSM encoding
package p25519_pkg;

    localparam int LIMB_W   = 16;
    localparam int N_LIMBS  = 16;
    localparam int CARRY_W  = 6;
    localparam int FOLD_HI  = 38;
    localparam int FOLD_TOP = 19;

    // 0x7fff...ffed: bit 255 clear, bits 254..5 set, low five bits 01101.
    localparam logic [255:0] P25519 = {1'b0, {250{1'b1}}, 5'b01101};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FOLD1 = 2'd1,
        FOLD2 = 2'd2,
        CSUB  = 2'd3
    } state_t;

endpackage

// File: rtl/mod_reduce_25519_if.sv
// Start/done bus between the product source and the reducer.
//   start     : request, sampled only while the reducer is IDLE
//   in        : 512-bit product, captured on the cycle start is accepted
//   out       : 256-bit residue, valid while done is high and held afterwards
//   done      : one-cycle completion pulse
//   busy      : high from the cycle after acceptance until done rises
//   state_dbg : current FSM state, for observation only
// Handshake: the master raises start with in valid; the request is taken at
// the first rising edge where start=1 and the reducer is IDLE. A start seen
// while busy is dropped, not queued. The master may change in freely after
// acceptance. done pulses for exactly one cycle with out valid in that cycle,
// and a new start may be presented in that same cycle.
interface mod_reduce_25519_if;
    import p25519_pkg::*;

    logic         start;
    logic [511:0] in;
    logic [255:0] out;
    logic         done;
    logic         busy;
    state_t       state_dbg;

    modport master (
        output start, in,
        input  out, done, busy, state_dbg
    );

    modport slave (
        input  start, in,
        output out, done, busy, state_dbg
    );

endinterface

// File: rtl/limb_fold_mac.sv
// Combinational limb multiply-accumulate: {cout, sum} = a + 38*b + cin.
//   a    : 16-bit limb of the low half
//   b    : 16-bit limb of the high half (weighted by 2^256 = 38)
//   cin  : 6-bit carry from the previous limb (at most 39)
//   sum  : 16-bit result limb
//   cout : 6-bit carry to the next limb (at most 39)
// Worst case 65535 + 38*65535 + 39 < 2^22, so 22 bits never overflow.
module limb_fold_mac
    import p25519_pkg::*;
(
    input  logic [LIMB_W-1:0]  a,
    input  logic [LIMB_W-1:0]  b,
    input  logic [CARRY_W-1:0] cin,
    output logic [LIMB_W-1:0]  sum,
    output logic [CARRY_W-1:0] cout
);

    localparam int SUM_W = LIMB_W + CARRY_W;

    logic [SUM_W-1:0] s;

    always_comb begin
        s    = SUM_W'(a) + SUM_W'(b) * SUM_W'(FOLD_HI) + SUM_W'(cin);
        sum  = s[LIMB_W-1:0];
        cout = s[SUM_W-1:LIMB_W];
    end

endmodule

// File: rtl/mod_reduce_25519.sv
// Sequential reducer of a 512-bit product modulo p = 2^255 - 19.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of mod_reduce_25519_if (start/in/out/done/busy/state_dbg)
// Flow: IDLE -> FOLD1 (16 cycles, one limb of lo + 38*hi per cycle)
//       -> FOLD2 (fold bits 255 and above back in with weight 19)
//       -> CSUB (one conditional subtraction of p) -> IDLE with done.
// done appears 18 cycles after acceptance; out holds until the next completion.
module mod_reduce_25519
    import p25519_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    mod_reduce_25519_if.slave    bus
);

    localparam int K_W = $clog2(N_LIMBS);

    state_t             state_q;
    logic [K_W-1:0]     k_q;
    logic [255:0]       lo_q;
    logic [255:0]       hi_q;
    logic [255:0]       r_q;
    logic [255:0]       u_q;
    logic [255:0]       out_q;
    logic [CARRY_W-1:0] carry_q;
    logic               done_q;
    logic               busy_q;

    logic [LIMB_W-1:0]  mac_sum;
    logic [CARRY_W-1:0] mac_cout;
    logic [6:0]         top;
    logic [10:0]        top_x19;
    logic [255:0]       u_next;
    logic [255:0]       red;

    // lo_q/hi_q shift right one limb per FOLD1 cycle, so the MAC always
    // sees limb k in the bottom 16 bits.
    limb_fold_mac u_mac (
        .a    (lo_q[LIMB_W-1:0]),
        .b    (hi_q[LIMB_W-1:0]),
        .cin  (carry_q),
        .sum  (mac_sum),
        .cout (mac_cout)
    );

    always_comb begin
        // Everything at weight 2^255 and above: the final carry (weight 2^256)
        // and r bit 255. Value < 78, so 19*top fits in 11 bits.
        top     = {carry_q, r_q[255]};
        top_x19 = 11'(top) * 11'(FOLD_TOP);
        u_next  = {1'b0, r_q[254:0]} + 256'(top_x19);
        // u < 2p, so a single conditional subtraction fully reduces it.
        red     = (u_q >= P25519) ? (u_q - P25519) : u_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        lo_q    <= bus.in[255:0];
                        hi_q    <= bus.in[511:256];
                        k_q     <= '0;
                        carry_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= FOLD1;
                    end
                end
                FOLD1: begin
                    // New limbs enter at the top; after 16 shifts limb 0
                    // sits in r_q[15:0].
                    r_q     <= {mac_sum, r_q[255:LIMB_W]};
                    lo_q    <= lo_q >> LIMB_W;
                    hi_q    <= hi_q >> LIMB_W;
                    carry_q <= mac_cout;
                    k_q     <= k_q + 1'b1;
                    if (k_q == K_W'(N_LIMBS - 1)) begin
                        state_q <= FOLD2;
                    end
                end
                FOLD2: begin
                    u_q     <= u_next;
                    state_q <= CSUB;
                end
                CSUB: begin
                    out_q   <= red;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mod_reduce_25519.sv
// Self-checking bench for mod_reduce_25519: directed corners, random
// products and timing corners, with expected residues queued at launch.
module tb_mod_reduce_25519;
    import p25519_pkg::*;

    // Prime derived independently of the package constant.
    localparam logic [255:0] P_REF = (256'd1 << 255) - 256'd19;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   cmp_cnt = 0;
    int   fail_cnt = 0;
    int   t0 = 0;
    int   last_done_cyc = 0;
    int   done_pulses = 0;
    int   collects = 0;

    logic [255:0] exp_q[$];

    mod_reduce_25519_if bus ();

    mod_reduce_25519 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done === 1'b1) done_pulses <= done_pulses + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Bit-serial long division remainder, MSB first.
    function automatic logic [255:0] ref_mod(input logic [511:0] v);
        logic [256:0] r;
        r = '0;
        for (int i = 511; i >= 0; i--) begin
            r = {r[255:0], v[i]};
            if (r >= {1'b0, P_REF}) r = r - {1'b0, P_REF};
        end
        return r[255:0];
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // ---------------- check / driver tasks ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive start for one cycle, record acceptance time.
    task automatic launch(input logic [511:0] v, input logic [255:0] exp);
        bus.start = 1'b1;
        bus.in    = v;
        exp_q.push_back(exp);
        @(negedge clk);
        t0        = cyc;
        bus.start = 1'b0;
        bus.in    = rand512();
    endtask

    // Wait for done; returns at the negedge inside the done cycle.
    task automatic collect(input string tag, input bit chk_busy);
        int  bcnt;
        bit  seen;
        logic [255:0] e;
        bcnt = 0;
        seen = 1'b0;
        collects++;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 256'(seen), 256'd1);
        if (seen) begin
            last_done_cyc = cyc;
            check({tag, "_latency"}, 256'(cyc - t0), 256'd18);
            check({tag, "_busy_in_done"}, 256'(bus.busy), 256'd0);
            if (chk_busy) check({tag, "_busy_cycles"}, 256'(bcnt), 256'd18);
            check({tag, "_queue_nonempty"}, 256'(exp_q.size() > 0), 256'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_out"}, bus.out, e);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] v, v2;
        logic [255:0] a, b;
        int d1, extra;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in    = '0;
        repeat (3) @(negedge clk);
        check("reset_out",   bus.out,                 256'd0);
        check("reset_done",  256'(bus.done),          256'd0);
        check("reset_busy",  256'(bus.busy),          256'd0);
        check("reset_state", 256'(bus.state_dbg),     256'(IDLE));
        reset = 1'b0;
        @(negedge clk);

        // Directed corners.
        launch(512'd0, 256'd0);                          collect("zero", 1'b1);
        @(negedge clk);
        launch({256'd0, P_REF}, 256'd0);                 collect("p", 1'b1);
        @(negedge clk);
        launch({256'd0, P_REF - 256'd1}, P_REF - 256'd1); collect("p_minus_1", 1'b1);
        @(negedge clk);
        launch(512'd1 << 255, 256'd19);                  collect("two_255", 1'b1);
        @(negedge clk);
        launch(512'd1 << 256, 256'd38);                  collect("two_256", 1'b1);
        @(negedge clk);
        launch({512{1'b1}}, 256'd1443);                  collect("all_ones", 1'b1);
        @(negedge clk);

        // Random 512-bit operands, some with saturated high limbs.
        for (int n = 0; n < 150; n++) begin
            v = rand512();
            if ($urandom_range(0, 3) == 0) v[511:256] = {256{1'b1}};
            if ($urandom_range(0, 7) == 0) v[255:0]   = {256{1'b1}};
            launch(v, ref_mod(v));
            collect("random", 1'b1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Products of random 256-bit pairs, as the multiplier would deliver.
        for (int n = 0; n < 40; n++) begin
            a = rand256();
            b = rand256();
            v = 512'(a) * 512'(b);
            launch(v, ref_mod(v));
            collect("product", 1'b1);
        end
        @(negedge clk);

        // start pulsed at acceptance+5 with another operand: ignored.
        v  = rand512();
        v2 = rand512();
        launch(v, ref_mod(v));
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.in    = v2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in    = rand512();
        collect("ignored_start", 1'b0);
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        check("ignored_start_no_second_done", 256'(extra), 256'd0);

        // start in the done cycle: accepted, second done 19 cycles later.
        v  = rand512();
        v2 = rand512();
        launch(v, ref_mod(v));
        collect("b2b_first", 1'b1);
        d1 = last_done_cyc;
        launch(v2, ref_mod(v2));
        collect("b2b_second", 1'b1);
        check("b2b_spacing", 256'(last_done_cyc - d1), 256'd19);
        @(negedge clk);

        // Reset at acceptance+8, then a clean run.
        v = rand512();
        launch(v, ref_mod(v));
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_out",   bus.out,             256'd0);
        check("midreset_done",  256'(bus.done),      256'd0);
        check("midreset_busy",  256'(bus.busy),      256'd0);
        check("midreset_state", 256'(bus.state_dbg), 256'(IDLE));
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        launch(512'd1 << 255, 256'd19);
        collect("after_reset", 1'b1);
        repeat (5) @(negedge clk);

        check("done_pulse_count", 256'(done_pulses), 256'(collects));
        check("queue_drained", 256'(exp_q.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
